// File: rtl/gmii_frame_gen_if.sv
// Frame-request and GMII byte-stream bundle for gmii_frame_gen.
// The master requests frames and observes the transmitted stream.
interface gmii_frame_gen_if #(
    parameter int LEN_W = 7,
    parameter int CNT_W = 16
);
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic             pattern_mode;
    logic [7:0]       seed;
    logic             err_en;
    logic [LEN_W-1:0] err_pos;
    logic [7:0]       txd;
    logic             tx_en;
    logic             tx_er;
    logic             txd_k;
    logic             busy;
    logic             frame_done;
    logic [CNT_W-1:0] frame_count;

    modport master (
        output start, frame_len, pattern_mode, seed, err_en, err_pos,
        input  txd, tx_en, tx_er, txd_k, busy, frame_done, frame_count
    );

    modport slave (
        input  start, frame_len, pattern_mode, seed, err_en, err_pos,
        output txd, tx_en, tx_er, txd_k, busy, frame_done, frame_count
    );
endinterface

// File: rtl/gmii_frame_gen.sv
// GMII-side frame source: idle pairs, /S/, payload, /T/, /R/ with
// programmable length, pattern, and single-byte error injection.
module gmii_frame_gen #(
    parameter int MAX_LEN    = 64,
    parameter int LEN_W      = 7,
    parameter int IDLE_PAIRS = 2,
    parameter int CNT_W      = 16
) (
    input logic             gtx_clk,
    input logic             reset_L,
    gmii_frame_gen_if.slave gen
);
    localparam logic [7:0] K_COMMA = 8'hBC;
    localparam logic [7:0] D_IDLE  = 8'h50;
    localparam logic [7:0] SYM_S   = 8'hFB;
    localparam logic [7:0] SYM_T   = 8'hFD;
    localparam logic [7:0] SYM_R   = 8'hAF;
    localparam logic [7:0] SYM_V   = 8'hFE;

    localparam int               PW      = $clog2(IDLE_PAIRS + 1) + 1;
    localparam logic [PW-1:0]    PAIRS   = PW'(IDLE_PAIRS);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE_K,
        IDLE_D,
        SOP,
        DATA,
        EOP,
        R1,
        R2
    } state_t;

    state_t state, state_nxt;
    logic   parity;

    logic [PW-1:0] pair_cnt, pair_inc;

    logic             slot_full;
    logic [LEN_W-1:0] slot_len, slot_ep;
    logic [7:0]       slot_seed;
    logic             slot_mode, slot_ee;

    logic [LEN_W-1:0] cur_len, cur_ep, idx;
    logic             cur_mode, cur_ee;
    logic [7:0]       pat;

    logic [7:0]       txd_q, txd_nxt;
    logic             en_q;
    logic             er_q, er_nxt;
    logic             k_q, k_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic [CNT_W-1:0] cnt_q;

    logic accept, last_byte, frame_end;

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    assign accept = gen.start && (gen.frame_len != '0)
                    && !slot_full && !busy_q;
    assign last_byte = (idx == cur_len - LEN_W'(1));
    assign pair_inc  = (pair_cnt == PAIRS) ? pair_cnt
                                           : pair_cnt + PW'(1);
    // busy is still high only on the first idle after the last /R/
    assign frame_end = (state == IDLE_K) && busy_q;

    always_comb begin
        state_nxt = state;
        txd_nxt   = K_COMMA;
        k_nxt     = 1'b1;
        er_nxt    = 1'b0;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE_K: begin
                state_nxt = IDLE_D;
                busy_nxt  = 1'b0;
                done_nxt  = busy_q;
            end
            IDLE_D: begin
                txd_nxt   = D_IDLE;
                state_nxt = (slot_full && pair_inc >= PAIRS) ? SOP
                                                             : IDLE_K;
            end
            SOP: begin
                txd_nxt   = SYM_S;
                busy_nxt  = 1'b1;
                state_nxt = DATA;
            end
            DATA: begin
                k_nxt = 1'b0;
                if (cur_ee && idx == cur_ep) begin
                    txd_nxt = SYM_V;
                    er_nxt  = 1'b1;
                end else begin
                    txd_nxt = pat;
                end
                state_nxt = last_byte ? EOP : DATA;
            end
            EOP: begin
                txd_nxt   = SYM_T;
                state_nxt = R1;
            end
            R1: begin
                txd_nxt   = SYM_R;
                // an extra /R/ keeps the next comma on an even cycle
                state_nxt = parity ? IDLE_K : R2;
            end
            R2: begin
                txd_nxt   = SYM_R;
                state_nxt = IDLE_K;
            end
            default: state_nxt = IDLE_K;
        endcase
    end

    always_ff @(posedge gtx_clk) begin
        if (!reset_L) begin
            state     <= IDLE_K;
            parity    <= 1'b0;
            pair_cnt  <= '0;
            slot_full <= 1'b0;
            slot_len  <= '0;
            slot_ep   <= '0;
            slot_seed <= '0;
            slot_mode <= 1'b0;
            slot_ee   <= 1'b0;
            cur_len   <= '0;
            cur_ep    <= '0;
            cur_mode  <= 1'b0;
            cur_ee    <= 1'b0;
            idx       <= '0;
            pat       <= '0;
            txd_q     <= '0;
            en_q      <= 1'b0;
            er_q      <= 1'b0;
            k_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state  <= state_nxt;
            parity <= ~parity;
            txd_q  <= txd_nxt;
            en_q   <= 1'b1;
            er_q   <= er_nxt;
            k_q    <= k_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;

            if (state == IDLE_D) begin
                pair_cnt <= pair_inc;
            end else if ((state == R1 || state == R2)
                         && state_nxt == IDLE_K) begin
                pair_cnt <= '0;
            end

            if (frame_end) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (state == SOP) begin
                slot_full <= 1'b0;
                cur_len   <= slot_len;
                cur_ep    <= slot_ep;
                cur_mode  <= slot_mode;
                cur_ee    <= slot_ee;
                pat       <= slot_seed;
                idx       <= '0;
            end else if (accept) begin
                slot_full <= 1'b1;
                slot_len  <= (gen.frame_len > LEN_MAX) ? LEN_MAX
                                                       : gen.frame_len;
                slot_ep   <= gen.err_pos;
                slot_seed <= gen.seed;
                slot_mode <= gen.pattern_mode;
                slot_ee   <= gen.err_en;
            end

            if (state == DATA) begin
                idx <= idx + LEN_W'(1);
                pat <= cur_mode ? lfsr_step(pat) : pat + 8'd1;
            end
        end
    end

    assign gen.txd         = txd_q;
    assign gen.tx_en       = en_q;
    assign gen.tx_er       = er_q;
    assign gen.txd_k       = k_q;
    assign gen.busy        = busy_q;
    assign gen.frame_done  = done_q;
    assign gen.frame_count = cnt_q;
endmodule

// File: tb/tb_gmii_frame_gen.sv
// Scoreboard bench for gmii_frame_gen: frames are modelled as byte lists
// when requested; a monitor tracks idle parity and pops frames on /S/.
module tb_gmii_frame_gen;
    localparam int MAX_LEN    = 64;
    localparam int LEN_W      = 7;
    localparam int IDLE_PAIRS = 2;
    localparam int CNT_W      = 16;

    logic gtx_clk = 1'b0;
    logic reset_L = 1'b0;
    logic rst_q   = 1'b0;

    int tests = 0;
    int fails = 0;

    gmii_frame_gen_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    gmii_frame_gen #(
        .MAX_LEN   (MAX_LEN),
        .LEN_W     (LEN_W),
        .IDLE_PAIRS(IDLE_PAIRS),
        .CNT_W     (CNT_W)
    ) dut (
        .gtx_clk(gtx_clk),
        .reset_L(reset_L),
        .gen    (bus)
    );

    always #5 gtx_clk = ~gtx_clk;
    always @(posedge gtx_clk) rst_q <= reset_L;

    // expected entries: {tx_er, txd_k, txd}; one length per frame
    logic [9:0] exp_bytes[$];
    int         exp_lens[$];

    bit         in_frame = 1'b0;
    bit         done_due = 1'b0;
    int         pos = 0;
    int         cur_n = 0;
    int         idx = 0;
    int         pairs = 0;
    int         exp_cnt = 0;
    logic [9:0] e;

    task automatic chk(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, req, $time);
        end
    endtask

    always @(negedge gtx_clk) begin
        if (!rst_q) begin
            chk("rst_txd", bus.txd, 0);
            chk("rst_tx_en", bus.tx_en, 0);
            chk("rst_tx_er", bus.tx_er, 0);
            chk("rst_txd_k", bus.txd_k, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.frame_done, 0);
            chk("rst_count", bus.frame_count, 0);
            exp_bytes.delete();
            exp_lens.delete();
            in_frame = 1'b0;
            done_due = 1'b0;
            idx      = 0;
            pairs    = 0;
            exp_cnt  = 0;
        end else begin
            chk("tx_en", bus.tx_en, 1);
            if (in_frame) begin
                e = exp_bytes.pop_front();
                chk("frame_txd", bus.txd, e[7:0]);
                chk("frame_k", bus.txd_k, e[8]);
                chk("frame_er", bus.tx_er, e[9]);
                chk("frame_busy", bus.busy, 1);
                chk("frame_done_low", bus.frame_done, 0);
                pos++;
                if (pos == cur_n) begin
                    in_frame = 1'b0;
                    done_due = 1'b1;
                    pairs    = 0;
                end
            end else if (bus.txd == 8'hFB && bus.txd_k) begin
                chk("sop_even", idx % 2, 0);
                chk("sop_gap", int'(pairs >= IDLE_PAIRS), 1);
                chk("sop_busy", bus.busy, 1);
                chk("sop_er", bus.tx_er, 0);
                chk("sop_expected", int'(exp_lens.size() != 0), 1);
                if (exp_lens.size() != 0) begin
                    cur_n    = exp_lens.pop_front();
                    pos      = 0;
                    in_frame = 1'b1;
                end
            end else begin
                chk("idle_txd", bus.txd, (idx % 2) ? 8'h50 : 8'hBC);
                chk("idle_k", bus.txd_k, 1);
                chk("idle_er", bus.tx_er, 0);
                chk("idle_busy", bus.busy, 0);
                chk("idle_done", bus.frame_done, int'(done_due));
                if (done_due) begin
                    exp_cnt++;
                    chk("frame_count", bus.frame_count,
                        exp_cnt % (1 << CNT_W));
                    done_due = 1'b0;
                end
                if (idx % 2 == 1) pairs++;
            end
            idx++;
        end
    end

    task automatic push_frame(input int len, input logic [7:0] sd,
                              input bit md, input bit ee, input int ep);
        int         l;
        logic [7:0] v;
        logic [7:0] b;
        l = (len > MAX_LEN) ? MAX_LEN : len;
        v = sd;
        for (int i = 0; i < l; i++) begin
            b = md ? v : 8'((int'(sd) + i) % 256);
            if (ee && i == ep) exp_bytes.push_back({2'b10, 8'hFE});
            else exp_bytes.push_back({2'b00, b});
            v = {v[6:0], ^(v & 8'hB8)};
        end
        exp_bytes.push_back({2'b01, 8'hFD});
        exp_bytes.push_back({2'b01, 8'hAF});
        // /S/ is even, so /R/ falls on len parity; even needs a second /R/
        if (l % 2 == 0) exp_bytes.push_back({2'b01, 8'hAF});
        exp_lens.push_back(l + 2 + ((l % 2 == 0) ? 1 : 0));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge gtx_clk);
        #1;
    endtask

    task automatic send(input int len, input logic [7:0] sd, input bit md,
                        input bit ee, input int ep, input bit acc);
        bus.start        = 1'b1;
        bus.frame_len    = LEN_W'(len);
        bus.seed         = sd;
        bus.pattern_mode = md;
        bus.err_en       = ee;
        bus.err_pos      = LEN_W'(ep);
        @(posedge gtx_clk);
        #1;
        bus.start = 1'b0;
        if (acc) push_frame(len, sd, md, ee, ep);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge gtx_clk);
            n++;
        end while ((exp_lens.size() != 0 || in_frame) && n < 2000);
        #1;
        chk("idle_timeout", int'(n < 2000), 1);
        if (n >= 2000) begin
            exp_lens.delete();
            exp_bytes.delete();
            in_frame = 1'b0;
        end
    endtask

    task automatic wait_in_frame(input int min_pos);
        int n;
        n = 0;
        while (!(in_frame && pos >= min_pos) && n < 500) begin
            @(posedge gtx_clk);
            n++;
        end
        #1;
        chk("reach_frame", int'(in_frame), 1);
    endtask

    initial begin
        int len;
        int ep;
        bus.start        = 1'b0;
        bus.frame_len    = '0;
        bus.seed         = '0;
        bus.pattern_mode = 1'b0;
        bus.err_en       = 1'b0;
        bus.err_pos      = '0;

        cyc(3);
        reset_L = 1'b1;
        cyc(6);

        send(10, 8'h00, 1'b0, 1'b0, 0, 1'b1);
        wait_idle();
        send(9, 8'h00, 1'b0, 1'b0, 0, 1'b1);
        wait_idle();
        send(6, 8'h10, 1'b0, 1'b1, 3, 1'b1);
        wait_idle();

        send(4, 8'h01, 1'b1, 1'b0, 0, 1'b1);
        wait_in_frame(1);
        send(5, 8'h77, 1'b0, 1'b0, 0, 1'b0);
        wait_idle();

        send(0, 8'h55, 1'b0, 1'b0, 0, 1'b0);
        cyc(12);
        wait_idle();

        send(8, 8'h20, 1'b0, 1'b0, 0, 1'b1);
        send(3, 8'h99, 1'b1, 1'b1, 1, 1'b0);
        wait_idle();

        send(100, 8'hF0, 1'b0, 1'b1, 64, 1'b1);
        wait_idle();
        send(5, 8'hA5, 1'b1, 1'b1, 5, 1'b1);
        wait_idle();
        send(1, 8'hFF, 1'b0, 1'b1, 0, 1'b1);
        wait_idle();

        for (int k = 0; k < 30; k++) begin
            cyc($urandom_range(0, 6));
            len = $urandom_range(1, 127);
            ep  = $urandom_range(0, (len < 120) ? len + 3 : 127);
            send(len, 8'($urandom), 1'($urandom), 1'($urandom), ep, 1'b1);
            wait_idle();
        end

        send(40, 8'h33, 1'b0, 1'b0, 0, 1'b1);
        wait_in_frame(5);
        reset_L = 1'b0;
        cyc(3);
        reset_L = 1'b1;
        cyc(2);
        send(7, 8'h42, 1'b1, 1'b1, 2, 1'b1);
        wait_idle();
        cyc(4);
        chk("final_queue_empty", exp_bytes.size(), 0);
        chk("final_count", exp_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
